// File: rtl/uart_tx_sched_if.sv
// Requester-side byte bus for uart_tx_sched: per-requester valid/data/last
// toward the scheduler, one-hot ready back to the sources.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART byte transmitter
// among NUM_REQ packet sources. A granted requester keeps the transmitter
// for a whole packet (ended by req_last or by MAX_LEN bytes).
// Optional build macro UART_TX_SCHED_HDR_EN: sends a header byte
// {4'hA, 2'b00, grant_id} ahead of each packet's payload.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [2:0]        baud_sel,
  uart_tx_sched_if.slave    req,
  output logic [2:0]        tx_baud_set,
  output logic              tx_send_en,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              pkt_done,
  output logic              len_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef UART_TX_SCHED_HDR_EN
    ST_HDR_SEND,
    ST_HDR_WAIT,
`endif
    ST_FETCH,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  rr_ptr;
  logic [7:0]  byte_cnt;
  logic        last_r;
  logic        len_hit_r;

  logic        any_valid;
  logic [1:0]  winner;
  logic        accept;
  logic [7:0]  grant_byte;
  logic        grant_last;
  logic        cnt_at_max;

  assign grant_byte = req.req_data[{grant_id, 3'b000} +: 8];
  assign grant_last = req.req_last[grant_id];
  assign cnt_at_max = (byte_cnt == 8'(MAX_LEN - 1));
  assign accept     = (state == ST_FETCH) && req.req_valid[grant_id];

  // Round-robin search: first valid requester upward from rr_ptr+1, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = rr_ptr;
    any_valid = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!any_valid && req.req_valid[2'(idx)]) begin
        any_valid = 1'b1;
        winner    = 2'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
`ifdef UART_TX_SCHED_HDR_EN
          state_nxt = ST_HDR_SEND;
`else
          state_nxt = ST_FETCH;
`endif
        end
      end
`ifdef UART_TX_SCHED_HDR_EN
      ST_HDR_SEND: state_nxt = ST_HDR_WAIT;
      ST_HDR_WAIT: if (tx_done) state_nxt = ST_FETCH;
`endif
      ST_FETCH:    if (accept) state_nxt = ST_SEND;
      ST_SEND:     state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          state_nxt = last_r ? ST_IDLE : ST_FETCH;
        end
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; pkt_done/len_err are combinational on the final tx_done.
  always_comb begin
    req.req_ready = '0;
    if (state == ST_FETCH) begin
      req.req_ready[grant_id] = req.req_valid[grant_id];
    end
`ifdef UART_TX_SCHED_HDR_EN
    tx_send_en = (state == ST_SEND) || (state == ST_HDR_SEND);
`else
    tx_send_en = (state == ST_SEND);
`endif
    busy     = (state != ST_IDLE);
    pkt_done = (state == ST_WAIT) && tx_done && last_r;
    len_err  = (state == ST_WAIT) && tx_done && last_r && len_hit_r;
  end

  // Datapath: baud capture, grant, byte capture, length tracking, pointer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_baud_set <= '0;
      tx_data     <= '0;
      grant_id    <= '0;
      rr_ptr      <= 2'(NUM_REQ - 1);
      byte_cnt    <= '0;
      last_r      <= 1'b0;
      len_hit_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_baud_set <= baud_sel;
          if (any_valid) begin
            grant_id <= winner;
            byte_cnt <= '0;
`ifdef UART_TX_SCHED_HDR_EN
            tx_data  <= {4'hA, 2'b00, winner};
`endif
          end
        end
        ST_FETCH: begin
          if (accept) begin
            tx_data   <= grant_byte;
            last_r    <= grant_last | cnt_at_max;
            len_hit_r <= cnt_at_max & ~grant_last;
            byte_cnt  <= byte_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          if (tx_done && last_r) begin
            rr_ptr <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
